hvac_dwell_ctrl: RTL and testbench
==================================

// Module: hvac_dwell_ctrl
// PURPOSE
//  Downstream of the thermostat (design): consumes its heating/cooling requests and drives the
//  physical heater/cooler enables. Enforces minimum on-time, minimum off-time and mutual exclusion.
//  Protects the plant from short-cycling when temperature hovers near a threshold.
// PARAMETERS
//  MIN_ON   4   min cycles an enable stays high once asserted (>=1)
//  MIN_OFF  3   rest cycles with both enables low after any run (>=1)
//  MAX_ON   16  max cycles in one run; used only with HVAC_MAX_ON_EN (> MIN_ON)
//  TIMER_W  8   dwell counter width; 2**TIMER_W-1 >= max(MIN_ON,MIN_OFF,MAX_ON)
// PORTS
//  clk        in   1  system clock, rising edge
//  rst_n      in   1  asynchronous, active-low reset
//  heating    in   1  heat request from thermostat
//  cooling    in   1  cool request from thermostat
//  heater_on  out  1  heater enable, registered
//  cooler_on  out  1  cooler enable, registered
//  busy       out  1  high in HEAT/COOL/REST
//  fault      out  1  sticky max-on timeout flag (0 when HVAC_MAX_ON_EN undefined)
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE, timer=0, heater_on=cooler_on=busy=fault=0.
//  - States: IDLE=2'b00, HEAT=2'b01, COOL=2'b10, REST=2'b11. All outputs decoded from registered state.
//  - Timer cleared to 0 on every state change; otherwise +1 per cycle, saturating at 2**TIMER_W-1.
//  - IDLE: heating&!cooling -> HEAT; cooling&!heating -> COOL; both or neither -> stay IDLE.
//    Latency: request sampled at edge N, enable high from edge N (visible in cycle N+1).
//  - HEAT: heater_on=1. -> REST when !heating && timer>=MIN_ON-1. Request drop earlier is ignored
//    until MIN_ON satisfied. cooling asserted while in HEAT is ignored (never both enables high).
//  - COOL: mirror of HEAT with cooling/cooler_on.
//  - REST: both enables 0, requests ignored; -> IDLE when timer==MIN_OFF-1.
//    Min gap between runs: MIN_OFF cycles REST + 1 cycle IDLE.
//  - Direct HEAT<->COOL transition forbidden; always passes through REST.
//  - heater_on&cooler_on==1 is unreachable; any illegal encoding recovers to REST.
//  - Reset mid-run: enables drop immediately (asynchronously); no REST dwell follows reset.
// CONFIGURATION
//  - HVAC_MAX_ON_EN defined: in HEAT/COOL, when timer==MAX_ON-1, force -> REST regardless of request,
//    set fault=1 (sticky until rst_n). With fault=1, IDLE takes no new runs (outputs stay 0).
//  - HVAC_MAX_ON_EN undefined: no run-length limit; fault tied to 1'b0; MAX_ON unused.
// STRUCTURE
//  - Shared include hvac_defs.vh: state encodings (HVAC_IDLE/HEAT/COOL/REST), default MIN_ON/MIN_OFF.
//  - Sub-module dwell_timer (TIMER_W): clear, saturating increment, count output; one instance.
//  - FSM, output decode, fault register in hvac_dwell_ctrl.
// TESTING (MIN_ON=4, MIN_OFF=3, MAX_ON=16, TIMER_W=8)
//  1. Reset: rst_n=0 mid-HEAT -> heater_on,cooler_on,busy,fault 0 within same cycle; IDLE on release.
//  2. Short pulse: heating=1 for 1 cycle -> heater_on high exactly 4 cycles, then 3 REST cycles
//     with both 0, then IDLE.
//  3. Long request: heating=1 for 10 cycles -> heater_on high 10 cycles, drops the edge after
//     heating falls (with timer>=3).
//  4. Mode flip: heating 1->0 and cooling 0->1 same cycle during HEAT -> cooler_on rises no earlier
//     than 4 cycles after heater_on falls; never overlap.
//  5. Conflict: heating=cooling=1 in IDLE -> both enables stay 0, state IDLE.
//  6. HVAC_MAX_ON_EN: cooling held 1 for 30 cycles -> cooler_on high 16 cycles, fault=1 sticky,
//     no further runs until reset; without macro cooler_on high all 30 cycles, fault=0.

Source files
------------

// File: rtl/hvac_dwell_ctrl_pkg.sv
// Shared definitions for the HVAC dwell controller: state encodings and
// default dwell parameters.
package hvac_dwell_ctrl_pkg;

    // Enable-state encodings; every 2-bit code is a named state.
    typedef enum logic [1:0] {
        HVAC_IDLE = 2'b00,
        HVAC_HEAT = 2'b01,
        HVAC_COOL = 2'b10,
        HVAC_REST = 2'b11
    } hvac_state_e;

    localparam int unsigned HVAC_MIN_ON_DEF  = 4;
    localparam int unsigned HVAC_MIN_OFF_DEF = 3;
    localparam int unsigned HVAC_MAX_ON_DEF  = 16;
    localparam int unsigned HVAC_TIMER_W_DEF = 8;

endpackage

// File: rtl/hvac_dwell_ctrl_dwell_timer.sv
// Dwell timer: counts cycles spent in the current state.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr_i      : synchronous clear (state change); count restarts at 0
//   count_o    : current dwell count, saturates at 2**TIMER_W-1
module hvac_dwell_ctrl_dwell_timer #(
    parameter int unsigned TIMER_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr_i,
    output logic [TIMER_W-1:0] count_o
);

    logic [TIMER_W-1:0] count_q;
    logic [TIMER_W-1:0] count_d;

    // Clear wins over increment; hold at all-ones instead of wrapping.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (count_q != {TIMER_W{1'b1}}) begin
            count_d = count_q + TIMER_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/hvac_dwell_ctrl.sv
// HVAC dwell controller: turns thermostat heat/cool requests into heater and
// cooler enables with minimum on-time, minimum rest time and mutual exclusion.
//   clk, rst_n : clock, asynchronous active-low reset
//   heating    : heat request
//   cooling    : cool request
//   heater_on  : heater enable (decoded from state register)
//   cooler_on  : cooler enable (decoded from state register)
//   busy       : high while heating, cooling or resting
//   fault      : sticky run-length timeout flag
// Optional feature macro: HVAC_MAX_ON_EN enables the MAX_ON run-length limit
// and the fault flag; without it fault is constant 0.
module hvac_dwell_ctrl
    import hvac_dwell_ctrl_pkg::*;
#(
    parameter int unsigned MIN_ON  = HVAC_MIN_ON_DEF,
    parameter int unsigned MIN_OFF = HVAC_MIN_OFF_DEF,
    parameter int unsigned MAX_ON  = HVAC_MAX_ON_DEF,
    parameter int unsigned TIMER_W = HVAC_TIMER_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic heating,
    input  logic cooling,
    output logic heater_on,
    output logic cooler_on,
    output logic busy,
    output logic fault
);

    localparam logic [TIMER_W-1:0] ON_LAST  = TIMER_W'(MIN_ON - 1);
    localparam logic [TIMER_W-1:0] OFF_LAST = TIMER_W'(MIN_OFF - 1);

    hvac_state_e        state_q;
    hvac_state_e        state_d;
    logic [TIMER_W-1:0] timer;
    logic               max_hit_c;
    logic               fault_q;

    // Timer restarts on every state transition.
    hvac_dwell_ctrl_dwell_timer #(
        .TIMER_W (TIMER_W)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (state_d != state_q),
        .count_o (timer)
    );

`ifdef HVAC_MAX_ON_EN
    localparam logic [TIMER_W-1:0] MAX_LAST = TIMER_W'(MAX_ON - 1);

    logic fault_d;

    assign max_hit_c = (timer == MAX_LAST);

    // Fault latches when a run is cut short by the length limit.
    always_comb begin
        fault_d = fault_q;
        if (((state_q == HVAC_HEAT) || (state_q == HVAC_COOL)) && max_hit_c) begin
            fault_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end
`else
    logic unused_max_on;

    assign max_hit_c     = 1'b0;
    assign fault_q       = 1'b0;
    assign unused_max_on = ^TIMER_W'(MAX_ON);
`endif

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            HVAC_IDLE: begin
                if (!fault_q) begin
                    if (heating && !cooling) begin
                        state_d = HVAC_HEAT;
                    end else if (cooling && !heating) begin
                        state_d = HVAC_COOL;
                    end
                end
            end
            HVAC_HEAT: begin
                if (max_hit_c || (!heating && (timer >= ON_LAST))) begin
                    state_d = HVAC_REST;
                end
            end
            HVAC_COOL: begin
                if (max_hit_c || (!cooling && (timer >= ON_LAST))) begin
                    state_d = HVAC_REST;
                end
            end
            HVAC_REST: begin
                if (timer == OFF_LAST) begin
                    state_d = HVAC_IDLE;
                end
            end
            default: state_d = HVAC_REST;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HVAC_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Outputs decode straight from the state flop so reset clears them at once.
    assign heater_on = (state_q == HVAC_HEAT);
    assign cooler_on = (state_q == HVAC_COOL);
    assign busy      = (state_q != HVAC_IDLE);
    assign fault     = fault_q;

endmodule

// File: tb/tb_hvac_dwell_ctrl.sv
// Self-checking bench for hvac_dwell_ctrl (MIN_ON=4, MIN_OFF=3, MAX_ON=16).
module tb_hvac_dwell_ctrl;

    localparam int unsigned MIN_ON  = 4;
    localparam int unsigned MIN_OFF = 3;
    localparam int unsigned MAX_ON  = 16;
    localparam int unsigned TIMER_W = 8;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic heating = 1'b0;
    logic cooling = 1'b0;
    logic heater_on;
    logic cooler_on;
    logic busy;
    logic fault;

    always #5 clk = ~clk;

    hvac_dwell_ctrl #(
        .MIN_ON  (MIN_ON),
        .MIN_OFF (MIN_OFF),
        .MAX_ON  (MAX_ON),
        .TIMER_W (TIMER_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .heating   (heating),
        .cooling   (cooling),
        .heater_on (heater_on),
        .cooler_on (cooler_on),
        .busy      (busy),
        .fault     (fault)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: which appliance is running (0 none, 1 heat, 2 cool), how many
    // cycles it has run, how many rest cycles remain, and the timeout flag.
    int m_kind = 0;
    int m_on   = 0;
    int m_rest = 0;
    bit m_fault = 1'b0;
    bit m_req;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_kind  = 0;
            m_on    = 0;
            m_rest  = 0;
            m_fault = 1'b0;
        end else if (m_kind != 0) begin
            m_req = (m_kind == 1) ? heating : cooling;
`ifdef HVAC_MAX_ON_EN
            if (m_on == int'(MAX_ON)) begin
                m_kind  = 0;
                m_rest  = MIN_OFF;
                m_fault = 1'b1;
            end else
`endif
            if (!m_req && m_on >= int'(MIN_ON)) begin
                m_kind = 0;
                m_rest = MIN_OFF;
            end else begin
                m_on++;
            end
        end else if (m_rest > 0) begin
            m_rest--;
        end else if (!m_fault && (heating ^ cooling)) begin
            m_kind = heating ? 1 : 2;
            m_on   = 1;
        end
    end

    // Per-cycle compare plus activity counters used by the directed checks.
    int   cyc      = 0;
    int   heat_cyc = 0;
    int   cool_cyc = 0;
    int   rest_cyc = 0;
    int   busy_cyc = 0;
    int   t_fall   = 0;
    int   t_rise   = 0;
    logic prev_heat = 1'b0;
    logic prev_cool = 1'b0;

    always @(negedge clk) begin
        cyc++;
        check("heater_on", int'(heater_on), int'(m_kind == 1));
        check("cooler_on", int'(cooler_on), int'(m_kind == 2));
        check("busy",      int'(busy),      int'(m_kind != 0 || m_rest > 0));
        check("fault",     int'(fault),     int'(m_fault));
        check("overlap",   int'(heater_on && cooler_on), 0);
        if (heater_on) heat_cyc++;
        if (cooler_on) cool_cyc++;
        if (busy) busy_cyc++;
        if (busy && !heater_on && !cooler_on) rest_cyc++;
        if (prev_heat && !heater_on) t_fall = cyc;
        if (!prev_cool && cooler_on) t_rise = cyc;
        prev_heat = heater_on;
        prev_cool = cooler_on;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    int b_h, b_c, b_r, b_b;

    initial begin
        // Reset state
        step(2);
        check("reset_heater", int'(heater_on), 0);
        check("reset_busy",   int'(busy), 0);
        check("reset_fault",  int'(fault), 0);
        rst_n = 1'b1;
        step(2);

        // Short pulse: 4 on cycles, 3 rest cycles
        b_h = heat_cyc; b_r = rest_cyc;
        heating = 1'b1; step(1);
        heating = 1'b0; step(12);
        check("pulse_on_cycles",   heat_cyc - b_h, 4);
        check("pulse_rest_cycles", rest_cyc - b_r, 3);

        // Long request follows the request length
        b_h = heat_cyc;
        heating = 1'b1; step(10);
        heating = 1'b0; step(12);
        check("long_on_cycles", heat_cyc - b_h, 10);

        // Mode flip goes through REST and one IDLE cycle
        b_h = heat_cyc; b_c = cool_cyc;
        heating = 1'b1; step(6);
        heating = 1'b0; cooling = 1'b1; step(8);
        cooling = 1'b0; step(14);
        check("flip_heat_cycles", heat_cyc - b_h, 6);
        check("flip_cool_cycles", cool_cyc - b_c, 4);
        check("flip_gap",         t_rise - t_fall, 4);

        // Conflicting requests start nothing
        b_h = heat_cyc; b_c = cool_cyc; b_b = busy_cyc;
        heating = 1'b1; cooling = 1'b1; step(6);
        check("conflict_runs", (heat_cyc - b_h) + (cool_cyc - b_c), 0);
        check("conflict_busy", busy_cyc - b_b, 0);
        heating = 1'b0; cooling = 1'b0; step(2);

        // Reset mid-HEAT drops everything within the cycle
        heating = 1'b1; step(3);
        check("pre_reset_heater", int'(heater_on), 1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("async_heater", int'(heater_on), 0);
        check("async_cooler", int'(cooler_on), 0);
        check("async_busy",   int'(busy), 0);
        check("async_fault",  int'(fault), 0);
        @(negedge clk);
        heating = 1'b0; step(1);
        rst_n = 1'b1; step(2);
        check("post_reset_idle", int'(busy), 0);

        // Held cooling request: limited run with the max-on feature
        b_c = cool_cyc;
        cooling = 1'b1; step(30);
        cooling = 1'b0; step(10);
`ifdef HVAC_MAX_ON_EN
        check("held_cool_cycles", cool_cyc - b_c, 16);
        check("held_fault", int'(fault), 1);
`else
        check("held_cool_cycles", cool_cyc - b_c, 30);
        check("held_fault", int'(fault), 0);
`endif
        b_h = heat_cyc;
        heating = 1'b1; step(6);
        heating = 1'b0; step(10);
`ifdef HVAC_MAX_ON_EN
        check("after_fault_runs", heat_cyc - b_h, 0);
`else
        check("after_fault_runs", heat_cyc - b_h, 6);
`endif

        // Reset clears the fault and runs resume
        rst_n = 1'b0; step(2);
        check("fault_cleared", int'(fault), 0);
        rst_n = 1'b1; step(1);
        b_h = heat_cyc;
        heating = 1'b1; step(1);
        heating = 1'b0; step(10);
        check("resume_on_cycles", heat_cyc - b_h, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
